gray_stream_decoder: RTL and testbench

GRAY_STREAM_DECODER -- requirements
Module: gray_stream_decoder

---
 rtl/gray_stream_decoder_if.sv | 31 +++
 rtl/gray_stream_decoder.sv | 170 +++++++++++++++++
 tb/tb_gray_stream_decoder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/gray_stream_decoder_if.sv
// Purpose: handshake and result bundle between a Gray-code source/sink and gray_stream_decoder.
// Latency: none; this is wiring only.
// Backpressure: carries in_valid/in_ready and out_valid/out_ready; the slave computes in_ready.
interface gray_stream_decoder_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  logic             resync;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] gray_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] binary_out;
  logic             dir_out;
  logic             step_err;
  logic [ERR_W-1:0] err_count;
  logic             fault;

  // Environment side: produces samples, consumes results.
  modport master (
    output resync, in_valid, gray_in, out_ready,
    input  in_ready, out_valid, binary_out, dir_out, step_err, err_count, fault
  );

  // Decoder side.
  modport slave (
    input  resync, in_valid, gray_in, out_ready,
    output in_ready, out_valid, binary_out, dir_out, step_err, err_count, fault
  );
endinterface

// File: rtl/gray_stream_decoder.sv
// Purpose: Gray-to-binary stream decoder with +/-1 step checking, direction tracking and fault FSM.
// Latency: 1 cycle from accept to out_valid/binary_out.
// Backpressure: single output register; in_ready = !out_valid || out_ready, result held while stalled.
module gray_stream_decoder #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  gray_stream_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] BIN_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  // Non-error accepts needed in S_FAULT before trusting the stream again.
  localparam logic [1:0]       GOOD_RUN_LAST = 2'd3;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] prev_bin_q;
  logic [1:0]       consec_err_q;
  logic [1:0]       good_run_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] binary_q;
  logic             dir_q;
  logic             step_err_q;
  logic [ERR_W-1:0] err_count_q;

  logic [WIDTH-1:0] bin_c;
  logic [WIDTH-1:0] prev_inc;
  logic [WIDTH-1:0] prev_dec;
  logic             step_rep;
  logic             step_up;
  logic             step_dn;
  logic             step_bad;
  logic             in_ready_c;
  logic             accept;
  logic             classify;
  logic             err_hit;
  logic             good_hit;

  // Gray to binary: each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    bin_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_c[i] = ^(bus.gray_in >> i);
    end
  end

  // Step classification against the stored reference, modulo 2^WIDTH so wrap is a legal step.
  assign prev_inc = prev_bin_q + BIN_ONE;
  assign prev_dec = prev_bin_q - BIN_ONE;
  assign step_rep = (bin_c == prev_bin_q);
  assign step_up  = (bin_c == prev_inc);
  assign step_dn  = (bin_c == prev_dec);
  assign step_bad = !(step_rep || step_up || step_dn);

  assign in_ready_c = !out_valid_q || bus.out_ready;
  assign accept     = bus.in_valid && in_ready_c;
  // A sample arriving with resync, or with no reference yet, only seeds prev_bin.
  assign classify   = (state_q != S_IDLE) && !bus.resync;
  assign err_hit    = accept && classify && step_bad;
  assign good_hit   = accept && classify && !step_bad;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: resync wins over any accept-driven transition.
  always_comb begin
    state_d = state_q;
    if (bus.resync) begin
      state_d = S_IDLE;
    end else if (accept) begin
      case (state_q)
        S_IDLE:  state_d = S_TRACK;
        S_TRACK: if (step_bad && (consec_err_q != 2'd0)) state_d = S_FAULT;
        S_FAULT: if (!step_bad && (good_run_q == GOOD_RUN_LAST)) state_d = S_TRACK;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs and handshake/result drive onto the bus.
  always_comb begin
    bus.fault      = (state_q == S_FAULT);
    bus.in_ready   = in_ready_c;
    bus.out_valid  = out_valid_q;
    bus.binary_out = binary_q;
    bus.dir_out    = dir_q;
    bus.step_err   = step_err_q;
    bus.err_count  = err_count_q;
  end

  // Consecutive-error and good-run counters feeding the fault entry/exit decisions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      consec_err_q <= 2'd0;
      good_run_q   <= 2'd0;
    end else if (bus.resync) begin
      consec_err_q <= 2'd0;
      good_run_q   <= 2'd0;
    end else if (err_hit) begin
      if (consec_err_q != 2'd3) begin
        consec_err_q <= consec_err_q + 2'd1;
      end
      good_run_q <= 2'd0;
    end else if (good_hit) begin
      consec_err_q <= 2'd0;
      if ((state_q == S_FAULT) && (good_run_q != GOOD_RUN_LAST)) begin
        good_run_q <= good_run_q + 2'd1;
      end else begin
        good_run_q <= 2'd0;
      end
    end
  end

  // Reference code: every accepted sample becomes the new reference, errors included.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_bin_q <= '0;
    end else if (accept) begin
      prev_bin_q <= bin_c;
    end
  end

  // Output register: load on accept, drop valid on consume, otherwise hold everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      binary_q    <= '0;
      dir_q       <= 1'b1;
      step_err_q  <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      binary_q    <= bin_c;
      step_err_q  <= classify && step_bad;
      if (classify && step_up) begin
        dir_q <= 1'b1;
      end else if (classify && step_dn) begin
        dir_q <= 1'b0;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Saturating step-error counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else if (err_hit && (err_count_q != ERR_MAX)) begin
      err_count_q <= err_count_q + ERR_ONE;
    end
  end

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Purpose: directed self-checking bench for gray_stream_decoder (WIDTH=4, ERR_W=8).
// Latency: checks results 1 ns after the edge that follows each accept.
// Backpressure: exercises out_ready stalls and simultaneous accept/consume.
module tb_gray_stream_decoder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Gray code of binary value i, hand-written.
  logic [3:0] gtab [16];

  gray_stream_decoder_if #(.WIDTH(4), .ERR_W(8)) bus ();

  gray_stream_decoder #(.WIDTH(4), .ERR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one sample for one edge, then idle the input.
  task automatic send(input logic [3:0] g, input logic rs);
    bus.in_valid = 1'b1;
    bus.gray_in  = g;
    bus.resync   = rs;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.resync   = 1'b0;
  endtask

  task automatic idle_edge();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1; bus.gray_in = 4'b1111; bus.resync = 1'b1; bus.out_ready = 1'b0;
    idle_edge(); idle_edge();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.binary_out !== 4'd0) begin n_bad++; $display("FAIL rst_binary: got %0d want 0", bus.binary_out); end
    n_cmp++; if (bus.dir_out !== 1'b1) begin n_bad++; $display("FAIL rst_dir: got %b want 1", bus.dir_out); end
    n_cmp++; if (bus.step_err !== 1'b0) begin n_bad++; $display("FAIL rst_step_err: got %b want 0", bus.step_err); end
    n_cmp++; if (bus.err_count !== 8'd0) begin n_bad++; $display("FAIL rst_err_count: got %0d want 0", bus.err_count); end
    n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault: got %b want 0", bus.fault); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    bus.in_valid = 1'b0; bus.resync = 1'b0; bus.out_ready = 1'b1;
    rst_n = 1'b1;
    idle_edge();
  endtask

  // Back-to-back full up-sweep including the 15 -> 0 wrap, out_ready held high.
  task automatic test_up_sweep();
    for (int i = 0; i <= 16; i++) begin
      send(gtab[i % 16], 1'b0);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL sweep_valid[%0d]: got %b want 1", i, bus.out_valid); end
      n_cmp++; if (bus.binary_out !== 4'(i % 16)) begin n_bad++; $display("FAIL sweep_bin[%0d]: got %0d want %0d", i, bus.binary_out, i % 16); end
      n_cmp++; if (bus.dir_out !== 1'b1) begin n_bad++; $display("FAIL sweep_dir[%0d]: got %b want 1", i, bus.dir_out); end
      n_cmp++; if (bus.step_err !== 1'b0) begin n_bad++; $display("FAIL sweep_err[%0d]: got %b want 0", i, bus.step_err); end
    end
    n_cmp++; if (bus.err_count !== 8'd0) begin n_bad++; $display("FAIL sweep_err_count: got %0d want 0", bus.err_count); end
  endtask

  task automatic test_down_step();
    send(4'b0000, 1'b0);
    n_cmp++; if (bus.binary_out !== 4'd0) begin n_bad++; $display("FAIL down_rep_bin: got %0d want 0", bus.binary_out); end
    send(4'b1000, 1'b0);
    n_cmp++; if (bus.binary_out !== 4'd15) begin n_bad++; $display("FAIL down_bin: got %0d want 15", bus.binary_out); end
    n_cmp++; if (bus.dir_out !== 1'b0) begin n_bad++; $display("FAIL down_dir: got %b want 0", bus.dir_out); end
    n_cmp++; if (bus.step_err !== 1'b0) begin n_bad++; $display("FAIL down_err: got %b want 0", bus.step_err); end
  endtask

  task automatic test_illegal_jump();
    bus.resync = 1'b1; idle_edge(); bus.resync = 1'b0;
    send(4'b0001, 1'b0);
    n_cmp++; if (bus.step_err !== 1'b0) begin n_bad++; $display("FAIL ill_seed_err: got %b want 0", bus.step_err); end
    send(4'b0101, 1'b0);
    n_cmp++; if (bus.binary_out !== 4'd6) begin n_bad++; $display("FAIL ill_bin: got %0d want 6", bus.binary_out); end
    n_cmp++; if (bus.step_err !== 1'b1) begin n_bad++; $display("FAIL ill_err: got %b want 1", bus.step_err); end
    n_cmp++; if (bus.err_count !== 8'd1) begin n_bad++; $display("FAIL ill_count: got %0d want 1", bus.err_count); end
    n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL ill_fault: got %b want 0", bus.fault); end
    send(4'b0100, 1'b0);
    n_cmp++; if (bus.binary_out !== 4'd7) begin n_bad++; $display("FAIL ill_next_bin: got %0d want 7", bus.binary_out); end
    n_cmp++; if (bus.step_err !== 1'b0) begin n_bad++; $display("FAIL ill_next_err: got %b want 0", bus.step_err); end
    n_cmp++; if (bus.dir_out !== 1'b1) begin n_bad++; $display("FAIL ill_next_dir: got %b want 1", bus.dir_out); end
  endtask

  // From prev=7: 12 and 3 are illegal, then 4,5,5,4 are legal.
  task automatic test_fault();
    logic [3:0] good_g [4];
    good_g = '{4'b0110, 4'b0111, 4'b0111, 4'b0110};
    send(4'b1010, 1'b0);
    n_cmp++; if (bus.err_count !== 8'd2) begin n_bad++; $display("FAIL flt_count1: got %0d want 2", bus.err_count); end
    n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL flt_first: got %b want 0", bus.fault); end
    send(4'b0010, 1'b0);
    n_cmp++; if (bus.binary_out !== 4'd3) begin n_bad++; $display("FAIL flt_bin: got %0d want 3", bus.binary_out); end
    n_cmp++; if (bus.fault !== 1'b1) begin n_bad++; $display("FAIL flt_enter: got %b want 1", bus.fault); end
    for (int i = 0; i < 4; i++) begin
      send(good_g[i], 1'b0);
      n_cmp++; if (bus.step_err !== 1'b0) begin n_bad++; $display("FAIL flt_good_err[%0d]: got %b want 0", i, bus.step_err); end
      n_cmp++; if (bus.fault !== (i < 3)) begin n_bad++; $display("FAIL flt_exit[%0d]: got %b want %b", i, bus.fault, (i < 3)); end
    end
    n_cmp++; if (bus.dir_out !== 1'b0) begin n_bad++; $display("FAIL flt_dir: got %b want 0", bus.dir_out); end
    n_cmp++; if (bus.err_count !== 8'd3) begin n_bad++; $display("FAIL flt_count: got %0d want 3", bus.err_count); end
  endtask

  // prev=4: accept 5 under stall, hold 6 pending for three cycles, then release.
  task automatic test_backpressure();
    idle_edge();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.gray_in = 4'b0111;
    idle_edge();
    bus.gray_in = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_rdy[%0d]: got %b want 0", i, bus.in_ready); end
      n_cmp++; if (bus.binary_out !== 4'd5) begin n_bad++; $display("FAIL bp_hold[%0d]: got %0d want 5", i, bus.binary_out); end
      if (i < 2) idle_edge();
    end
    bus.out_ready = 1'b1; #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_rdy: got %b want 1", bus.in_ready); end
    idle_edge();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.binary_out !== 4'd6) begin n_bad++; $display("FAIL bp_next_bin: got %0d want 6", bus.binary_out); end
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_next_valid: got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.step_err !== 1'b0) begin n_bad++; $display("FAIL bp_next_err: got %b want 0", bus.step_err); end
    idle_edge();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_consumed: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.binary_out !== 4'd6) begin n_bad++; $display("FAIL bp_no_dup: got %0d want 6", bus.binary_out); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    send(4'b0100, 1'b0);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL rm_pre_valid: got %b want 1", bus.out_valid); end
    rst_n = 1'b0; bus.in_valid = 1'b1; bus.gray_in = 4'b1111; bus.resync = 1'b1; bus.out_ready = 1'b1;
    idle_edge();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.binary_out !== 4'd0) begin n_bad++; $display("FAIL rm_bin: got %0d want 0", bus.binary_out); end
    n_cmp++; if (bus.dir_out !== 1'b1) begin n_bad++; $display("FAIL rm_dir: got %b want 1", bus.dir_out); end
    n_cmp++; if (bus.err_count !== 8'd0) begin n_bad++; $display("FAIL rm_count: got %0d want 0", bus.err_count); end
    n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL rm_fault: got %b want 0", bus.fault); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rm_rdy: got %b want 1", bus.in_ready); end
    rst_n = 1'b1; bus.in_valid = 1'b0; bus.resync = 1'b0;
    idle_edge();
  endtask

  task automatic test_resync();
    send(4'b0000, 1'b0);
    send(4'b0001, 1'b0);
    send(4'b0111, 1'b0);
    n_cmp++; if (bus.err_count !== 8'd1) begin n_bad++; $display("FAIL rs_pre_count: got %0d want 1", bus.err_count); end
    bus.resync = 1'b1; idle_edge(); bus.resync = 1'b0;
    n_cmp++; if (bus.binary_out !== 4'd5) begin n_bad++; $display("FAIL rs_hold_bin: got %0d want 5", bus.binary_out); end
    n_cmp++; if (bus.step_err !== 1'b1) begin n_bad++; $display("FAIL rs_hold_err: got %b want 1", bus.step_err); end
    send(4'b1100, 1'b0);
    n_cmp++; if (bus.binary_out !== 4'd8) begin n_bad++; $display("FAIL rs_bin: got %0d want 8", bus.binary_out); end
    n_cmp++; if (bus.step_err !== 1'b0) begin n_bad++; $display("FAIL rs_err: got %b want 0", bus.step_err); end
    n_cmp++; if (bus.err_count !== 8'd1) begin n_bad++; $display("FAIL rs_count: got %0d want 1", bus.err_count); end
    // Jump 8 -> 14 arriving together with resync is not an error.
    send(4'b1001, 1'b1);
    n_cmp++; if (bus.binary_out !== 4'd14) begin n_bad++; $display("FAIL rs_acc_bin: got %0d want 14", bus.binary_out); end
    n_cmp++; if (bus.step_err !== 1'b0) begin n_bad++; $display("FAIL rs_acc_err: got %b want 0", bus.step_err); end
    n_cmp++; if (bus.err_count !== 8'd1) begin n_bad++; $display("FAIL rs_acc_count: got %0d want 1", bus.err_count); end
    // Landed in S_IDLE: next jump only seeds, the one after is checked.
    send(4'b0101, 1'b0);
    n_cmp++; if (bus.step_err !== 1'b0) begin n_bad++; $display("FAIL rs_idle_err: got %b want 0", bus.step_err); end
    send(4'b1100, 1'b0);
    n_cmp++; if (bus.step_err !== 1'b1) begin n_bad++; $display("FAIL rs_track_err: got %b want 1", bus.step_err); end
    n_cmp++; if (bus.err_count !== 8'd2) begin n_bad++; $display("FAIL rs_track_count: got %0d want 2", bus.err_count); end
  endtask

  // Alternate 0 and 8 so every accept is an error, well past 255.
  task automatic test_saturation();
    for (int i = 0; i < 260; i++) begin
      send((i % 2 == 0) ? 4'b0000 : 4'b1100, 1'b0);
      if (i == 252) begin
        n_cmp++; if (bus.err_count !== 8'd255) begin n_bad++; $display("FAIL sat_reach: got %0d want 255", bus.err_count); end
      end
    end
    n_cmp++; if (bus.err_count !== 8'd255) begin n_bad++; $display("FAIL sat_hold: got %0d want 255", bus.err_count); end
    n_cmp++; if (bus.fault !== 1'b1) begin n_bad++; $display("FAIL sat_fault: got %b want 1", bus.fault); end
  endtask

  initial begin
    gtab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    bus.in_valid  = 1'b0;
    bus.gray_in   = 4'b0000;
    bus.resync    = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_up_sweep();
    test_down_step();
    test_illegal_jump();
    test_fault();
    test_backpressure();
    test_reset_mid();
    test_resync();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
